// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the SRAM port arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_PRI0_EN.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int req_idx_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int REQ_IDX_W   = req_idx_w(4);
  localparam int BURST_CNT_W = burst_cnt_w(16);

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after
// rr_ptr, wrapping, returned both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic             found;
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] slot;
    // NOTE: every output and temporary gets a default first, so no path
    // through the loop can leave a value unassigned and infer a latch.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    slot   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      slot = pos[IDX_W-1:0];
      if (!found && req[slot]) begin
        found        = 1'b1;
        onehot[slot] = 1'b1;
        idx          = slot;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one SRAM port with locked bursts and read return.
// Define MEM_ARB_PRI0_EN to give requester 0 absolute priority when idle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_rd,
  output logic                          ram_wr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int IDX_W = req_idx_w(NUM_REQ);
  localparam int CNT_W = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic [NUM_REQ-1:0] pick_req, pick_onehot, gnt_vec, rvalid_q;
  logic [IDX_W-1:0]   pick_idx, gnt_idx;
  logic               gnt_any, gnt_wr, gnt_last;

  // Requester 0 is handled outside the rotation when it has priority.
`ifdef MEM_ARB_PRI0_EN
  assign pick_req = req & ~NUM_REQ'(1);
`else
  assign pick_req = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (pick_req),
    .rr_ptr  (rr_ptr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx)
  );

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] n;
    n = (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
`ifdef MEM_ARB_PRI0_EN
    if (n == '0) n = IDX_W'(1);
`endif
    return n;
  endfunction

  always_comb begin
    gnt_vec = '0;
    gnt_idx = '0;
    if (!rst) begin
      if (state_q == LOCK) begin
        gnt_idx = owner_q;
        gnt_vec = req & (NUM_REQ'(1) << owner_q);
      end else begin
`ifdef MEM_ARB_PRI0_EN
        if (req[0]) begin
          gnt_vec = NUM_REQ'(1);
        end else begin
          gnt_vec = pick_onehot;
          gnt_idx = pick_idx;
        end
`else
        gnt_vec = pick_onehot;
        gnt_idx = pick_idx;
`endif
      end
    end
  end

  assign gnt      = gnt_vec;
  assign gnt_any  = |gnt_vec;
  assign gnt_wr   = req_wr[gnt_idx];
  assign gnt_last = req_last[gnt_idx];

  assign ram_addr  = gnt_any ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign ram_wdata = gnt_any ? req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ram_rd    = gnt_any & ~gnt_wr;
  assign ram_wr    = gnt_any & gnt_wr;

  // Only accepted beats move the FSM; owner gaps leave the lock untouched.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    beat_cnt_inc = beat_cnt_q + CNT_W'(1);
    if (gnt_any) begin
      if (state_q == IDLE) begin
        if (gnt_last) begin
          rr_ptr_d = next_ptr(gnt_idx);
        end else begin
          state_d    = LOCK;
          owner_d    = gnt_idx;
          beat_cnt_d = CNT_W'(1);
        end
      end else if (gnt_last || beat_cnt_inc == BURST_MAX) begin
        state_d    = IDLE;
        rr_ptr_d   = next_ptr(owner_q);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= gnt_vec & {NUM_REQ{~gnt_wr}};
    end
  end

  // Masking with rst keeps a read granted just before reset from surfacing.
  assign rvalid = rvalid_q & {NUM_REQ{~rst}};
  assign rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against an arbitration model and a
// shadow memory, plus directed scenarios for the documented corner cases.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_wr, req_last;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_rd, ram_wr;

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM port behind the arbiter: registered read, 1-cycle latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_owner, m_ptr, m_beats;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]  obs_gnt, obs_rvalid;
  logic [DW-1:0] obs_rdata;
  logic          obs_rd, obs_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int nxt(input int i);
    int n = (i + 1) % N;
`ifdef MEM_ARB_PRI0_EN
    if (n == 0) n = 1;
`endif
    return n;
  endfunction

  function automatic int model_pick();
    if (rst) return -1;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
`ifdef MEM_ARB_PRI0_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
`ifdef MEM_ARB_PRI0_EN
      if (i == 0) continue;
`endif
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic [AW-1:0] a;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_rv = '0;
      return;
    end
    m_rv = '0;
    if (g < 0) return;
    a = req_addr[g*AW +: AW];
    if (req_wr[g]) ref_mem[a] = req_wdata[g*DW +: DW];
    else begin
      m_rv    = N'(1) << g;
      m_rdata = ref_mem[a];
    end
    if (m_owner < 0) begin
      if (req_last[g]) m_ptr = nxt(g);
      else begin m_owner = g; m_beats = 1; end
    end else begin
      m_beats++;
      if (req_last[g] || m_beats == MB) begin
        m_owner = -1; m_ptr = nxt(g); m_beats = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int            g;
    logic [N-1:0]  eg;
    logic          ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    g   = model_pick();
    eg  = '0; ewr = 1'b0; ea = '0; ed = '0;
    if (g >= 0) begin
      eg  = N'(1) << g;
      ewr = req_wr[g];
      ea  = req_addr[g*AW +: AW];
      ed  = req_wdata[g*DW +: DW];
    end
    obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
    obs_rd = ram_rd; obs_wr = ram_wr;
    check("gnt", gnt, eg);
    check("ram_wr", ram_wr, (g >= 0) && ewr);
    check("ram_rd", ram_rd, (g >= 0) && !ewr);
    check("ram_addr", ram_addr, ea);
    check("ram_wdata", ram_wdata, ed);
    check("rvalid", rvalid, rst ? '0 : m_rv);
    if (!rst && m_rv != '0) check("rdata", rdata, m_rdata);
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic drive(input int i, input bit r, input bit wr, input bit last,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; req_wr[i] = wr; req_last[i] = last;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req = '0; req_wr = '0; req_last = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Random requester agents
  bit            a_req [N], a_wr [N], a_gap [N], a_started [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wdata [N];
  int            a_left [N];

  task automatic agent_start(input int i);
    a_req[i] = 1'b1; a_wr[i] = 1'($urandom_range(0, 1));
    a_addr[i] = AW'($urandom_range(0, 63)); a_wdata[i] = $urandom;
    a_left[i] = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(2, 24));
    a_started[i] = 1'b0; a_gap[i] = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5;
      ref_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5;
    end
    ram_rdata = '0;
    m_owner = -1; m_ptr = 0; m_beats = 0; m_rv = '0; m_rdata = '0;
    clear_all();
    rst = 1'b1;
    req = '1; req_last = '1;
    cycle();
    check("rst_gnt", obs_gnt, '0);
    check("rst_rd_wr", {obs_rd, obs_wr}, 2'b00);
    do_reset();

`ifdef MEM_ARB_PRI0_EN
    for (int i = 0; i < N; i++) drive(i, 1, 0, 1, AW'(i), '0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("pri0_hold", obs_gnt, 4'b0001);
    end
    req[0] = 1'b0;
    for (int c = 1; c < N; c++) begin
      cycle();
      check("pri0_rot", obs_gnt, N'(1) << c);
    end
`else
    // Alternating single reads from requesters 1 and 3
    drive(1, 1, 0, 1, 10'h011, '0);
    drive(3, 1, 0, 1, 10'h033, '0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("rr_alt", obs_gnt, (c % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // Locked 4-beat read burst from requester 2, then wrap to requester 0
    do_reset();
    drive(1, 1, 0, 1, 10'h005, '0);
    cycle();
    check("pre_burst", obs_gnt, 4'b0010);
    clear_all();
    drive(0, 1, 0, 1, 10'h001, '0);
    drive(1, 1, 0, 1, 10'h002, '0);
    for (int b = 0; b < 4; b++) begin
      drive(2, 1, 0, (b == 3), AW'(10'h010 + b), '0);
      cycle();
      check("burst_own", obs_gnt, 4'b0100);
    end
    req[2] = 1'b0;
    cycle();
    check("burst_wrap", obs_gnt, 4'b0001);

    // Forced release after MAX_BURST beats
    do_reset();
    drive(1, 1, 1, 0, 10'h020, 32'h1000_0000);
    cycle();
    cnt = (obs_gnt == 4'b0010) ? 1 : 0;
    drive(3, 1, 0, 1, 10'h030, '0);
    for (int b = 1; b < MB; b++) begin
      drive(1, 1, 1, 0, AW'(10'h020 + b), 32'h1000_0000 + b);
      cycle();
      if (obs_gnt == 4'b0010) cnt++;
    end
    check("burst_len", cnt, MB);
    cycle();
    check("forced_next", obs_gnt, 4'b1000);
    req[3] = 1'b0;
    cycle();
    check("regrant", obs_gnt, 4'b0010);

    // Write then read back through different requesters
    do_reset();
    drive(3, 1, 1, 1, 10'h3FF, 32'hDEAD_BEEF);
    cycle();
    check("wr_issue", obs_wr, 1'b1);
    clear_all();
    drive(0, 1, 0, 1, 10'h3FF, '0);
    cycle();
    check("rd_issue", obs_rd, 1'b1);
    clear_all();
    cycle();
    check("rd_valid", obs_rvalid, 4'b0001);
    check("rd_data", obs_rdata, 32'hDEAD_BEEF);

    // Reset in the middle of a locked read burst
    do_reset();
    drive(2, 1, 0, 0, 10'h007, '0);
    cycle();
    check("lock_start", obs_gnt, 4'b0100);
    rst = 1'b1;
    drive(2, 1, 0, 0, 10'h008, '0);
    cycle();
    check("rst_lock_gnt", obs_gnt, '0);
    check("rst_lock_rv", obs_rvalid, '0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1, 0, 1, AW'(i + 64), '0);
    cycle();
    check("post_rst_gnt", obs_gnt, 4'b0001);
    check("post_rst_rv", obs_rvalid, '0);
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_req[i] = 1'b0; a_gap[i] = 1'b0; a_started[i] = 1'b0; a_left[i] = 1;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        drive(i, a_req[i] && !a_gap[i], a_wr[i], (a_left[i] == 1), a_addr[i], a_wdata[i]);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        a_gap[i] = 1'b0;
        if (obs_gnt[i]) begin
          a_started[i] = 1'b1;
          if (a_left[i] == 1) a_req[i] = 1'b0;
          else begin
            a_left[i]--;
            a_addr[i]++;
            a_wdata[i] = $urandom;
          end
        end else if (!a_req[i]) begin
          if ($urandom_range(0, 2) == 0) agent_start(i);
        end else if (!a_started[i]) begin
          if ($urandom_range(0, 15) == 0) a_req[i] = 1'b0;
        end else begin
          a_gap[i] = ($urandom_range(0, 7) == 0);
        end
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter sharing one port of a dual-port baseband SRAM among NUM_REQ requesters, e.g. correlator dump writer, acquisition engine and CPU host interface. Drives the RAM port's addr/rd/wr/wdata and returns read data, tagged by a one-hot valid, to the requester that issued the read. Supports locked bursts so a requester can hold the port for up to MAX_BURST consecutive beats.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 32, RAM data width
- MAX_BURST, 16, maximum beats per locked grant before forced release (2..256)
- clk  input  1  sole clock; RAM port uses the same clock
- rst  input  1  reset, synchronous, active-high
- req  input  NUM_REQ  per-requester access request
- req_wr  input  NUM_REQ  1 = write, 0 = read, per requester
- req_last  input  NUM_REQ  1 = final beat of burst (single access: hold 1)
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
- gnt  output  NUM_REQ  one-hot/zero; beat of requester i accepted this cycle
- rvalid  output  NUM_REQ  one-hot/zero; rdata belongs to requester i
- rdata  output  DATA_WIDTH  read data, shared by all requesters
- ram_addr  output  ADDR_WIDTH  to RAM port address
- ram_rd  output  1  to RAM port read enable
- ram_wr  output  1  to RAM port write enable
- ram_wdata  output  DATA_WIDTH  to RAM port write data
- ram_rdata  input  DATA_WIDTH  from RAM port read data (registered in RAM, 1-cycle latency)

## Operation
- States: IDLE, LOCK. Registers: rr_ptr (highest-priority index), owner, beat_cnt.
- IDLE: winner = first set req scanning from rr_ptr upward, wrapping. gnt[winner]=1 in the same cycle; the beat is issued to the RAM that cycle. If no req, gnt=0, ram_rd=ram_wr=0.
- Accepted beat with req_last=1: stay IDLE, rr_ptr <= winner+1 (mod NUM_REQ).
- Accepted beat with req_last=0: go to LOCK, owner <= winner, beat_cnt <= 1.
- LOCK: only owner can be granted; gnt[owner]=req[owner]; other requesters wait. Gaps (owner req=0) keep the lock, with no beat and no count.
- LOCK release: on the accepted beat with req_last=1, or when beat_cnt reaches MAX_BURST on that accepted beat (forced). Release -> IDLE, rr_ptr <= owner+1, beat_cnt <= 0.
- RAM mux: ram_addr/ram_wdata select the granted requester's fields. ram_rd = grant & ~req_wr; ram_wr = grant & req_wr. When there is no grant, ram_addr/ram_wdata hold 0.
- Read return: rvalid <= one-hot of a granted read, registered; rdata = ram_rdata passthrough, valid only when rvalid≠0.
- Requesters hold req/addr/wdata/wr/last stable until gnt. Changing or dropping an ungranted request is legal.

## Timing
- Grant: combinational, same cycle as req (0-cycle arbitration in IDLE and LOCK).
- Read data: rvalid/rdata in cycle N+1 for a read granted in cycle N. One beat per cycle sustained.
- Write: committed at the RAM on the clock edge ending the grant cycle.
- Back-to-back: a different requester may be granted the cycle after a release.
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, rvalid=0. During rst: gnt=0, ram_rd=ram_wr=0, ram_addr=0, ram_wdata=0.
- Reset mid-burst: lock dropped. An in-flight read's rvalid is suppressed, so no rvalid appears in the cycle after rst.

## Configuration
- MEM_ARB_PRI0_EN defined: requester 0 has absolute priority in IDLE and wins regardless of rr_ptr. LOCK is still honoured, so requester 0 waits for the burst release. Requesters 1..NUM_REQ-1 remain round-robin among themselves; rr_ptr skips 0.
- MEM_ARB_PRI0_EN undefined: all requesters are equal round-robin as above.

## Structure
- Shared package mem_arb_pkg: state encoding (IDLE=1'b0, LOCK=1'b1), helper constants REQ_IDX_W=clog2(NUM_REQ) and BURST_CNT_W=clog2(MAX_BURST+1).
- Sub-module rr_pick: combinational rotating priority picker. Inputs req and rr_ptr; outputs one-hot and index.
- Top: state/owner/beat_cnt registers, RAM mux, rvalid pipeline.

## Test plan
- Reset then req=4'b1010 held with last=1: gnt cycles 4'b0010, 4'b1000, 4'b0010... Each read returns rvalid matching the gnt one cycle later, with rdata = previously written mem value.
- Req 2 bursts 4 reads (addr 0x10..0x13, last on 4th) while req 0 and 1 request: only gnt[2] for 4 cycles, then gnt 4'b0001 (rr_ptr=3 wraps to 0).
- MAX_BURST=16, req 1 holds last=0 for 20 beats: forced release after beat 16, the next grant goes to another waiting requester, and req 1 is re-granted later as a new arbitration.
- Write 0xDEADBEEF at 0x3FF by req 3, then read 0x3FF by req 0: ram_wr then ram_rd in consecutive cycles, rvalid=4'b0001 and rdata=0xDEADBEEF.
- Assert rst during LOCK with a read in flight: next cycle rvalid=0 and gnt=0. After release of rst, req=4'b1111 is granted to requester 0 first.
- With MEM_ARB_PRI0_EN, req=4'b1111 continuously with last=1: gnt=4'b0001 every cycle. After req0 drops, gnt rotates 1,2,3.
